// File: rtl/dcache_sa.sv
// dcache_sa: set-associative, write-back, write-allocate data cache with true-LRU replacement.
// Optional feature macro DCACHE_SA_STATS_EN adds saturating hit_cnt_o / miss_cnt_o counters.
module dcache_sa #(
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          p1_data_i,
  input  logic [31:0]          p1_addr_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [31:0]          p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
`ifdef DCACHE_SA_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int IDX   = $clog2(SETS);
  localparam int TAGW  = 32 - OFF - IDX;
  localparam int WSELW = OFF - 2;
  localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [WAYW-1:0] AGE_MAX = WAYW'(WAYS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB_REQ = 2'd1,
    RF_REQ = 2'd2,
    FILL   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [WAYW-1:0]       vic_q, vic_d;
  logic [WAYS-1:0]       valid_q [SETS];
  logic [WAYS-1:0]       valid_d [SETS];
  logic [WAYS-1:0]       dirty_q [SETS];
  logic [WAYS-1:0]       dirty_d [SETS];
  logic [TAGW-1:0]       tag_q   [SETS][WAYS];
  logic [TAGW-1:0]       tag_d   [SETS][WAYS];
  logic [WAYW-1:0]       age_q   [SETS][WAYS];
  logic [WAYW-1:0]       age_d   [SETS][WAYS];
  logic [LINE_BITS-1:0]  data_q  [SETS][WAYS];
  logic [LINE_BITS-1:0]  data_d  [SETS][WAYS];

  logic [IDX-1:0]        idx_s;
  logic [TAGW-1:0]       tag_s;
  logic [WSELW-1:0]      wsel_s;
  logic [1:0]            unused_addr_s;
  logic                  req_s;
  logic [WAYS-1:0]       hit_vec_s;
  logic                  hit_s;
  logic [WAYW-1:0]       hit_way_s;
  logic [WAYW-1:0]       vic_s;
  logic [WAYW-1:0]       vic_age_s;
  logic [LINE_BITS-1:0]  rd_line_s;
  logic [31:0]           rd_word_s;
  logic                  lru_en_s;
  logic [WAYW-1:0]       lru_way_s;
  logic                  hit_evt_s;
  logic                  miss_evt_s;

  assign idx_s         = p1_addr_i[OFF +: IDX];
  assign tag_s         = p1_addr_i[31 -: TAGW];
  assign wsel_s        = p1_addr_i[2 +: WSELW];
  assign unused_addr_s = p1_addr_i[1:0];
  assign req_s         = p1_MemRead_i | p1_MemWrite_i;

  // Tag compare, victim choice: lowest invalid way, else the oldest way.
  always_comb begin
    hit_way_s = {WAYW{1'b0}};
    vic_age_s = {WAYW{1'b0}};
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s);
      hit_way_s    = hit_way_s | (hit_vec_s[w] ? WAYW'(w) : {WAYW{1'b0}});
      vic_age_s    = (age_q[idx_s][w] == AGE_MAX) ? WAYW'(w) : vic_age_s;
    end
    vic_s = vic_age_s;
    for (int w = WAYS - 1; w >= 0; w--) begin
      vic_s = valid_q[idx_s][w] ? vic_s : WAYW'(w);
    end
    hit_s = |hit_vec_s;
  end

  assign rd_line_s  = data_q[idx_s][hit_way_s];
  assign rd_word_s  = rd_line_s[{wsel_s, 5'd0} +: 32];
  assign p1_data_o  = (req_s && hit_s) ? rd_word_s : 32'd0;
  assign p1_stall_o = req_s && (!hit_s || (state_q != IDLE));

  // Next-state, array updates and LRU ageing.
  always_comb begin
    state_d    = state_q;
    vic_d      = vic_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    data_d     = data_q;
    lru_en_s   = 1'b0;
    lru_way_s  = hit_way_s;
    hit_evt_s  = 1'b0;
    miss_evt_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s && !hit_s) begin
          vic_d      = vic_s;
          miss_evt_s = 1'b1;
          state_d    = (valid_q[idx_s][vic_s] && dirty_q[idx_s][vic_s]) ? WB_REQ : RF_REQ;
        end else if (req_s) begin
          lru_en_s  = 1'b1;
          hit_evt_s = 1'b1;
          dirty_d[idx_s][hit_way_s] = dirty_q[idx_s][hit_way_s] | p1_MemWrite_i;
          data_d[idx_s][hit_way_s][{wsel_s, 5'd0} +: 32] = p1_MemWrite_i ? p1_data_i : rd_word_s;
        end else begin
          state_d = IDLE;
        end
      end
      WB_REQ: state_d = mem_ack_i ? RF_REQ : WB_REQ;
      RF_REQ: begin
        if (mem_ack_i) begin
          state_d                = FILL;
          valid_d[idx_s][vic_q]  = 1'b1;
          dirty_d[idx_s][vic_q]  = 1'b0;
          tag_d[idx_s][vic_q]    = tag_s;
          data_d[idx_s][vic_q]   = mem_data_i;
          lru_en_s               = 1'b1;
          lru_way_s              = vic_q;
        end else begin
          state_d = RF_REQ;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    age_d = age_q;
    for (int w = 0; w < WAYS; w++) begin
      age_d[idx_s][w] = !lru_en_s ? age_q[idx_s][w]
                      : (WAYW'(w) == lru_way_s) ? {WAYW{1'b0}}
                      : (age_q[idx_s][w] < age_q[idx_s][lru_way_s]) ? age_q[idx_s][w] + WAYW'(1)
                      : age_q[idx_s][w];
    end
  end

  // Memory-side request, driven from the current state only.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = {LINE_BITS{1'b0}};
    case (state_q)
      WB_REQ: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx_s][vic_q], idx_s, {OFF{1'b0}}};
        mem_data_o   = data_q[idx_s][vic_q];
      end
      RF_REQ: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag_s, idx_s, {OFF{1'b0}}};
      end
      default: begin
        mem_enable_o = 1'b0;
      end
    endcase
  end

  // Control state and line metadata.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      vic_q   <= {WAYW{1'b0}};
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= {WAYS{1'b0}};
        dirty_q[s] <= {WAYS{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= {TAGW{1'b0}};
          age_q[s][w] <= WAYW'(w);
        end
      end
    end else begin
      state_q <= state_d;
      vic_q   <= vic_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      age_q   <= age_d;
    end
  end

  // Line data needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

`ifdef DCACHE_SA_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        was_fill_q, was_fill_d;

  // The hit that completes a refilled access is not a fresh hit.
  always_comb begin
    was_fill_d = (state_q == FILL);
    hit_cnt_d  = (hit_evt_s && !was_fill_q && (hit_cnt_q != 32'hFFFF_FFFF)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
    miss_cnt_d = (miss_evt_s && (miss_cnt_q != 32'hFFFF_FFFF)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
  end

  // Statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
      was_fill_q <= 1'b0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      was_fill_q <= was_fill_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_stats_s;
  assign unused_stats_s = hit_evt_s ^ miss_evt_s;
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Directed table-driven bench for dcache_sa (WAYS=2, SETS=16, LINE_BITS=256) with a latency-10 memory model.
module tb_dcache_sa;
  localparam int LB  = 256;
  localparam int LAT = 10;

  logic          clk_i, rst_i;
  logic [31:0]   p1_data_i, p1_addr_i;
  logic          rd, wr;
  logic [31:0]   p1_data_o;
  logic          p1_stall_o;
  logic [LB-1:0] mem_data_i, mem_data_o;
  logic          ack_model, ack_man;
  logic [31:0]   mem_addr_o;
  logic          mem_enable_o, mem_write_o;
  logic          auto_mem;
`ifdef DCACHE_SA_STATS_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
  int            exp_hit, exp_miss;
`endif

  int total, bad;
  logic [LB-1:0] mem_m [int];
  logic [31:0]   wb_addr_q [$];
  logic [LB-1:0] wb_data_q [$];
  logic [31:0]   rf_addr_q [$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stalls;
    logic        chk;
    logic [31:0] data;
  } vec_t;

  vec_t vt  [21];
  vec_t vt2 [8];

  dcache_sa #(.WAYS(2), .SETS(16), .LINE_BITS(LB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .p1_data_i    (p1_data_i),
    .p1_addr_i    (p1_addr_i),
    .p1_MemRead_i (rd),
    .p1_MemWrite_i(wr),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (ack_model | ack_man),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o)
`ifdef DCACHE_SA_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Unwritten memory holds 0xA500_0000 | byte address in every word.
  function automatic logic [LB-1:0] line_of(int a);
    logic [LB-1:0] l;
    if (mem_m.exists(a)) l = mem_m[a];
    else for (int i = 0; i < LB / 32; i++) l[i*32 +: 32] = 32'hA500_0000 | (32'(a) + 32'(i * 4));
    return l;
  endfunction

  initial begin : mem_model
    int cnt;
    int a;
    cnt = 0;
    ack_model = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (ack_model) begin
        ack_model = 1'b0;
        cnt = 0;
      end
      if (mem_enable_o && auto_mem) begin
        cnt++;
        if (cnt == LAT) begin
          a = int'(mem_addr_o);
          if (mem_write_o) begin
            mem_m[a] = mem_data_o;
            wb_addr_q.push_back(mem_addr_o);
            wb_data_q.push_back(mem_data_o);
          end else begin
            mem_data_i = line_of(a);
            rf_addr_q.push_back(mem_addr_o);
          end
          ack_model = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] q);
    @(negedge clk_i);
    rd = r; wr = w; p1_addr_i = a; p1_data_i = d;
    #1;
    stalls = 0;
    while (p1_stall_o === 1'b1 && stalls < 200) begin
      @(negedge clk_i);
      #1;
      stalls++;
    end
    q = p1_data_o;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int st;
    logic [31:0] q;
    access(v.rd, v.wr, v.addr, v.wdata, st, q);
    chk({nm, "_stall"}, 32'(st), 32'(v.stalls));
    if (v.chk) chk({nm, "_data"}, q, v.data);
`ifdef DCACHE_SA_STATS_EN
    if (v.rd || v.wr) begin
      if (v.stalls > 0) exp_miss++;
      else exp_hit++;
    end
`endif
  endtask

  initial begin : main
    logic [LB-1:0] ln;
    logic [LB-1:0] wbl;
    total = 0; bad = 0;
    rst_i = 1'b1; rd = 1'b0; wr = 1'b0; p1_addr_i = 32'd0; p1_data_i = 32'd0;
    ack_man = 1'b0; auto_mem = 1'b1;
    ln = line_of(32'h40);
    ln[63:32] = 32'h1234_5678;
    mem_m[32'h40] = ln;

    //               rd    wr    addr          wdata         st  chk   data
    vt[0]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         12, 1'b1, 32'h1234_5678};
    vt[1]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          0, 1'b1, 32'h1234_5678};
    vt[2]  = '{1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF,  0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          0, 1'b1, 32'hDEAD_BEEF};
    vt[4]  = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,          0, 1'b1, 32'hA500_0048};
    vt[5]  = '{1'b1, 1'b0, 32'h0000_1040, 32'h0,         12, 1'b1, 32'hA500_1040};
    vt[6]  = '{1'b1, 1'b0, 32'h0000_2040, 32'h0,         22, 1'b1, 32'hA500_2040};
    vt[7]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         12, 1'b1, 32'hDEAD_BEEF};
    vt[8]  = '{1'b1, 1'b0, 32'h0000_0060, 32'h0,         12, 1'b1, 32'hA500_0060};
    vt[9]  = '{1'b1, 1'b0, 32'h0000_1064, 32'h0,         12, 1'b1, 32'hA500_1064};
    vt[10] = '{1'b1, 1'b0, 32'h0000_0068, 32'h0,          0, 1'b1, 32'hA500_0068};
    vt[11] = '{1'b1, 1'b0, 32'h0000_207C, 32'h0,         12, 1'b1, 32'hA500_207C};
    vt[12] = '{1'b1, 1'b0, 32'h0000_0060, 32'h0,          0, 1'b1, 32'hA500_0060};
    vt[13] = '{1'b1, 1'b0, 32'h0000_1060, 32'h0,         12, 1'b1, 32'hA500_1060};
    vt[14] = '{1'b1, 1'b1, 32'h0000_006C, 32'hCAFE_F00D,  0, 1'b0, 32'h0};
    vt[15] = '{1'b1, 1'b0, 32'h0000_006C, 32'h0,          0, 1'b1, 32'hCAFE_F00D};
    vt[16] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,          0, 1'b1, 32'h0};
    vt[17] = '{1'b0, 1'b1, 32'h0000_2064, 32'h1111_2222, 12, 1'b0, 32'h0};
    vt[18] = '{1'b1, 1'b0, 32'h0000_2064, 32'h0,          0, 1'b1, 32'h1111_2222};
    vt[19] = '{1'b1, 1'b0, 32'h0000_3060, 32'h0,         22, 1'b1, 32'hA500_3060};
    vt[20] = '{1'b1, 1'b0, 32'h0000_006C, 32'h0,         22, 1'b1, 32'hCAFE_F00D};

    vt2[0] = '{1'b1, 1'b0, 32'h0000_00A0, 32'h0,         12, 1'b1, 32'hA500_00A0};
    vt2[1] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         12, 1'b1, 32'hA500_0040};
    vt2[2] = '{1'b1, 1'b0, 32'h0000_1040, 32'h0,         12, 1'b1, 32'hA500_1040};
    vt2[3] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,          0, 1'b1, 32'hDEAD_BEEF};
    vt2[4] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,          0, 1'b1, 32'hA500_0048};
    vt2[5] = '{1'b1, 1'b0, 32'h0000_00A4, 32'h0,          0, 1'b1, 32'hA500_00A4};
    vt2[6] = '{1'b1, 1'b0, 32'h0000_1044, 32'h0,          0, 1'b1, 32'hA500_1044};
    vt2[7] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          0, 1'b1, 32'hA500_0040};

    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_mem_en",   32'(mem_enable_o), 32'd0);
    chk("rst_mem_wr",   32'(mem_write_o),  32'd0);
    chk("rst_mem_addr", mem_addr_o,        32'd0);
    chk("rst_mem_data", mem_data_o[31:0],  32'd0);
    chk("rst_stall",    32'(p1_stall_o),   32'd0);
    chk("rst_data",     p1_data_o,         32'd0);
`ifdef DCACHE_SA_STATS_EN
    chk("rst_hit_cnt",  hit_cnt_o,  32'd0);
    chk("rst_miss_cnt", miss_cnt_o, 32'd0);
`endif
    rst_i = 1'b0;

    for (int i = 0; i < 21; i++) run_vec(vt[i], $sformatf("v%0d", i));

    chk("first_rf_count", 32'(rf_addr_q.size() > 0), 32'd1);
    if (rf_addr_q.size() > 0) chk("first_rf_addr", rf_addr_q[0], 32'h40);
    chk("wb_count", 32'(wb_addr_q.size()), 32'd3);
    if (wb_addr_q.size() >= 3) begin
      chk("wb0_addr", wb_addr_q[0], 32'h40);
      wbl = wb_data_q[0];
      chk("wb0_word1", wbl[63:32], 32'hDEAD_BEEF);
      chk("wb1_addr", wb_addr_q[1], 32'h60);
      wbl = wb_data_q[1];
      chk("wb1_word3", wbl[127:96], 32'hCAFE_F00D);
      chk("wb2_addr", wb_addr_q[2], 32'h2060);
      wbl = wb_data_q[2];
      chk("wb2_word1", wbl[63:32], 32'h1111_2222);
    end

    // Asynchronous reset while a refill is outstanding, then a stray ack.
    auto_mem = 1'b0;
    @(negedge clk_i);
    rd = 1'b1; wr = 1'b0; p1_addr_i = 32'hA0;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rfq_en",    32'(mem_enable_o), 32'd1);
    chk("rfq_wr",    32'(mem_write_o),  32'd0);
    chk("rfq_addr",  mem_addr_o,        32'hA0);
    chk("rfq_stall", 32'(p1_stall_o),   32'd1);
    #2;
    rst_i = 1'b1; rd = 1'b0;
    #1;
    chk("arst_mem_en",   32'(mem_enable_o), 32'd0);
    chk("arst_mem_wr",   32'(mem_write_o),  32'd0);
    chk("arst_mem_addr", mem_addr_o,        32'd0);
    chk("arst_mem_data", mem_data_o[31:0],  32'd0);
    chk("arst_stall",    32'(p1_stall_o),   32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    ack_man = 1'b1;
    @(negedge clk_i);
    ack_man = 1'b0;
    #1;
    chk("late_ack_en",    32'(mem_enable_o), 32'd0);
    chk("late_ack_stall", 32'(p1_stall_o),   32'd0);
    auto_mem = 1'b1;
`ifdef DCACHE_SA_STATS_EN
    exp_hit = 0;
    exp_miss = 0;
`endif

    for (int i = 0; i < 8; i++) run_vec(vt2[i], $sformatf("r%0d", i));

`ifdef DCACHE_SA_STATS_EN
    @(negedge clk_i);
    rd = 1'b0; wr = 1'b0;
    #1;
    chk("hit_cnt",  hit_cnt_o,  32'(exp_hit));
    chk("miss_cnt", miss_cnt_o, 32'(exp_miss));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
